// File: rtl/reg_stage_pkg.sv
// Shared definitions for the register-stage control blocks: FSM encodings and default width.
package reg_stage_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/serial_nibble_loader_bit_counter.sv
// Accepted-bit counter: synchronous clear, count enable, and a flag raised on the
// enable that brings the count to WIDTH. Saturates at WIDTH.
module bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_FULL)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && !clr_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/serial_nibble_loader.sv
// Serial-to-parallel front end of the nibble register: frames WIDTH bits under
// valid/ready, then presents D_out with a one-cycle load/done strobe.
module serial_nibble_loader
  import reg_stage_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic             abort,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [WIDTH-1:0] D_out,
  output logic             load,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             in_idle, in_shift, accept, cnt_clr, cnt_en, last_bit;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_shift = (state_q == ST_SHIFT);
  assign accept   = in_shift && ser_valid;
  assign cnt_clr  = (in_idle && start) || (in_shift && abort);
  assign cnt_en   = accept && !abort;

  always_comb begin
    if (MSB_FIRST) begin
      sr_d = {sr_q[WIDTH-2:0], ser_data};
    end else begin
      sr_d = {ser_data, sr_q[WIDTH-1:1]};
    end
  end

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk   (clk),
    .clrn  (clrn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (last_bit)
  );

  // Abort is checked first so it wins over a final bit arriving in the same cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SHIFT;
            sr_q    <= '0;
          end
        end
        ST_SHIFT: begin
          if (abort) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
          end else if (ser_valid) begin
            sr_q <= sr_d;
            if (last_bit) state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign ser_ready = in_shift;
  assign busy      = in_shift || (state_q == ST_COMMIT);
  assign load      = (state_q == ST_COMMIT);
  assign done      = (state_q == ST_COMMIT);
  assign D_out     = sr_q;

endmodule
